risc16_seq_ctrl: RTL and testbench

Multi-cycle sequencing controller for the 16-bit RISC datapath. It replaces the single-cycle control decode with a state machine that steps each instruction through fetch, decode, execute, memory and write-back. It also handles wait-states on a shared instruction/data memory through a req/ack handshake. It sits between the datapath (instruction register opcode, ALU zero flag) and the unified memory port, and drives every datapath mux and write-enable.

---
 rtl/risc16_pkg.sv | 38 +++
 rtl/risc16_ctrl_decode.sv | 77 +++++++
 rtl/risc16_seq_ctrl.sv | 97 +++++++++
 tb/tb_risc16_seq_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/risc16_pkg.sv
// Shared encodings for the 16-bit RISC multi-cycle sequencing controller.
package risc16_pkg;

  localparam logic [3:0] OP_LD  = 4'b0000;
  localparam logic [3:0] OP_ST  = 4'b0001;
  localparam logic [3:0] OP_BEQ = 4'b1011;
  localparam logic [3:0] OP_BNE = 4'b1100;
  localparam logic [3:0] OP_JMP = 4'b1101;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  localparam logic [1:0] PC_PLUS2  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_RST,
    ST_FETCH,
    ST_DECODE,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_WB_MEM,
    ST_EXEC_R,
    ST_WB_R,
    ST_BRANCH,
    ST_JUMP,
    ST_TRAP
  } state_t;

  // R-type instructions occupy the contiguous opcode range 0010..1001.
  function automatic logic is_rtype(input logic [3:0] op);
    return (op >= 4'b0010) && (op <= 4'b1001);
  endfunction

endpackage

// File: rtl/risc16_ctrl_decode.sv
// Combinational map from sequencer state to every datapath mux select and enable.
module risc16_ctrl_decode
  import risc16_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write
);

  // Everything idles at zero; each state raises only the controls it needs.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS2;
    alu_src_b  = 1'b0;
    alu_op     = ALU_ADD;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ack;
        pc_write = mem_ack;
      end
      ST_MEM_ADDR: begin
        alu_src_b = 1'b1;
      end
      ST_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      ST_MEM_WR: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = 1'b1;
      end
      ST_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_EXEC_R: begin
        alu_op = ALU_FUNC;
      end
      ST_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        alu_op   = ALU_SUB;
        pc_src   = PC_BRANCH;
        pc_write = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
      end
      ST_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/risc16_seq_ctrl.sv
// Multi-cycle sequencer: state register, sticky trap flag and retired-instruction counter.
module risc16_seq_ctrl
  import risc16_pkg::*;
#(
  parameter int unsigned RET_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             trap,
  output logic [RET_W-1:0] retired
);

  state_t state_q;
  state_t state_next;
  logic   retire;

  risc16_ctrl_decode u_decode (
    .state      (state_q),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write)
  );

  // State register; reset always lands in RST so an in-flight request is abandoned.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RST;
    else       state_q <= state_next;
  end

  // Next-state sequencing; memory states wait on ack, TRAP only leaves through reset.
  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_RST:      state_next = ST_FETCH;
      ST_FETCH:    if (mem_ack) state_next = ST_DECODE;
      ST_DECODE: begin
        if ((opcode == OP_LD) || (opcode == OP_ST))       state_next = ST_MEM_ADDR;
        else if (is_rtype(opcode))                        state_next = ST_EXEC_R;
        else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) state_next = ST_BRANCH;
        else if (opcode == OP_JMP)                        state_next = ST_JUMP;
        else                                              state_next = ST_TRAP;
      end
      ST_MEM_ADDR: state_next = (opcode == OP_ST) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   if (mem_ack) state_next = ST_WB_MEM;
      ST_MEM_WR:   if (mem_ack) state_next = ST_FETCH;
      ST_WB_MEM:   state_next = ST_FETCH;
      ST_EXEC_R:   state_next = ST_WB_R;
      ST_WB_R:     state_next = ST_FETCH;
      ST_BRANCH:   state_next = ST_FETCH;
      ST_JUMP:     state_next = ST_FETCH;
      ST_TRAP:     state_next = ST_TRAP;
      default:     state_next = ST_RST;
    endcase
  end

  assign retire = ((state_q == ST_MEM_WR) && mem_ack) ||
                  (state_q == ST_WB_MEM) || (state_q == ST_WB_R) ||
                  (state_q == ST_BRANCH) || (state_q == ST_JUMP);

  // Trap is raised when DECODE sees an illegal opcode and holds until reset.
  always_ff @(posedge clk) begin
    if (reset)                                             trap <= 1'b0;
    else if ((state_q == ST_DECODE) && (state_next == ST_TRAP)) trap <= 1'b1;
  end

  // Retired counter bumps on the last cycle of each completed instruction and wraps.
  always_ff @(posedge clk) begin
    if (reset)       retired <= '0;
    else if (retire) retired <= retired + RET_W'(1);
  end

endmodule

// File: tb/tb_risc16_seq_ctrl.sv
// Directed self-checking bench for the multi-cycle sequencing controller.
module tb_risc16_seq_ctrl;

  // Control vector: {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, trap}
  localparam logic [13:0] C_IDLE     = 14'h0000;
  localparam logic [13:0] C_FETCH_W  = 14'h2000;
  localparam logic [13:0] C_FETCH_A  = 14'h2600;
  localparam logic [13:0] C_MEM_ADDR = 14'h0040;
  localparam logic [13:0] C_MEM_RD   = 14'h2800;
  localparam logic [13:0] C_MEM_WR   = 14'h3800;
  localparam logic [13:0] C_WB_MEM   = 14'h0006;
  localparam logic [13:0] C_EXEC_R   = 14'h0020;
  localparam logic [13:0] C_WB_R     = 14'h000A;
  localparam logic [13:0] C_BR_TAKE  = 14'h0290;
  localparam logic [13:0] C_BR_SKIP  = 14'h0090;
  localparam logic [13:0] C_JUMP     = 14'h0300;
  localparam logic [13:0] C_TRAP     = 14'h0001;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic        zero;
  logic        mem_ack;
  logic        mem_req, mem_we, iord, ir_write, pc_write, alu_src_b;
  logic        reg_dst, mem_to_reg, reg_write, trap;
  logic [1:0]  pc_src, alu_op;
  logic [15:0] retired;
  logic [13:0] ctl;

  logic        wrap_reset;
  logic        w_req, w_we, w_iord, w_irw, w_pcw, w_asb, w_rdst, w_m2r, w_rw, w_trap;
  logic [1:0]  w_pcsrc, w_aluop;
  logic [3:0]  w_retired;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  assign ctl = {mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, trap};

  risc16_seq_ctrl #(.RET_W(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .trap(trap), .retired(retired)
  );

  // Narrow-counter instance running back-to-back JMPs to exercise wraparound quickly.
  risc16_seq_ctrl #(.RET_W(4)) dut_wrap (
    .clk(clk), .reset(wrap_reset), .opcode(4'b1101), .zero(1'b0), .mem_ack(1'b1),
    .mem_req(w_req), .mem_we(w_we), .iord(w_iord), .ir_write(w_irw),
    .pc_write(w_pcw), .pc_src(w_pcsrc), .alu_src_b(w_asb), .alu_op(w_aluop),
    .reg_dst(w_rdst), .mem_to_reg(w_m2r), .reg_write(w_rw),
    .trap(w_trap), .retired(w_retired)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic z, input logic ack, input logic rst);
    opcode  = op;
    zero    = z;
    mem_ack = ack;
    reset   = rst;
  endtask

  // Check the current cycle's controls and counter, then advance one clock.
  task automatic runCycle(input string tag, input logic [13:0] expCtl, input logic [15:0] expRet);
    #1;
    checkOutput({tag, "_ctl"}, {18'd0, ctl}, {18'd0, expCtl});
    checkOutput({tag, "_ret"}, {16'd0, retired}, {16'd0, expRet});
    @(posedge clk);
    #1;
  endtask

  initial begin
    wrap_reset = 1'b1;
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    runCycle("reset_hold", C_IDLE, 16'd0);
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
    runCycle("rst_state", C_IDLE, 16'd0);

    // ADD with immediate ack: 4 cycles
    applyStimulus(4'b0010, 1'b0, 1'b1, 1'b0);
    runCycle("add_fetch", C_FETCH_A, 16'd0);
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
    runCycle("add_decode", C_IDLE, 16'd0);
    runCycle("add_exec", C_EXEC_R, 16'd0);
    runCycle("add_wb", C_WB_R, 16'd0);

    // LD with two wait cycles in both FETCH and MEM_RD: 9 cycles
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    runCycle("ld_fetch_w1", C_FETCH_W, 16'd1);
    runCycle("ld_fetch_w2", C_FETCH_W, 16'd1);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    runCycle("ld_fetch_ack", C_FETCH_A, 16'd1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    runCycle("ld_decode", C_IDLE, 16'd1);
    runCycle("ld_addr", C_MEM_ADDR, 16'd1);
    runCycle("ld_rd_w1", C_MEM_RD, 16'd1);
    runCycle("ld_rd_w2", C_MEM_RD, 16'd1);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    runCycle("ld_rd_ack", C_MEM_RD, 16'd1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    runCycle("ld_wb", C_WB_MEM, 16'd1);

    // ST with ack held high through non-memory states (ignored there)
    applyStimulus(4'b0001, 1'b0, 1'b1, 1'b0);
    runCycle("st_fetch", C_FETCH_A, 16'd2);
    runCycle("st_decode", C_IDLE, 16'd2);
    runCycle("st_addr", C_MEM_ADDR, 16'd2);
    runCycle("st_wr_ack", C_MEM_WR, 16'd2);

    // BEQ zero=1 taken, BNE zero=1 not taken, BNE zero=0 taken
    applyStimulus(4'b1011, 1'b1, 1'b1, 1'b0);
    runCycle("beq_fetch", C_FETCH_A, 16'd3);
    applyStimulus(4'b1011, 1'b1, 1'b0, 1'b0);
    runCycle("beq_decode", C_IDLE, 16'd3);
    runCycle("beq_branch", C_BR_TAKE, 16'd3);
    applyStimulus(4'b1100, 1'b1, 1'b1, 1'b0);
    runCycle("bne_fetch", C_FETCH_A, 16'd4);
    applyStimulus(4'b1100, 1'b1, 1'b0, 1'b0);
    runCycle("bne_decode", C_IDLE, 16'd4);
    runCycle("bne_z1_branch", C_BR_SKIP, 16'd4);
    applyStimulus(4'b1100, 1'b0, 1'b1, 1'b0);
    runCycle("bne2_fetch", C_FETCH_A, 16'd5);
    applyStimulus(4'b1100, 1'b0, 1'b0, 1'b0);
    runCycle("bne2_decode", C_IDLE, 16'd5);
    runCycle("bne_z0_branch", C_BR_TAKE, 16'd5);

    // JMP
    applyStimulus(4'b1101, 1'b0, 1'b1, 1'b0);
    runCycle("jmp_fetch", C_FETCH_A, 16'd6);
    applyStimulus(4'b1101, 1'b0, 1'b0, 1'b0);
    runCycle("jmp_decode", C_IDLE, 16'd6);
    runCycle("jmp_jump", C_JUMP, 16'd6);

    // Reset while MEM_WR is still waiting for ack
    applyStimulus(4'b0001, 1'b0, 1'b1, 1'b0);
    runCycle("st2_fetch", C_FETCH_A, 16'd7);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    runCycle("st2_decode", C_IDLE, 16'd7);
    runCycle("st2_addr", C_MEM_ADDR, 16'd7);
    runCycle("st2_wr_wait", C_MEM_WR, 16'd7);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b1);
    runCycle("st2_wr_reset", C_MEM_WR, 16'd7);
    applyStimulus(4'b0001, 1'b0, 1'b1, 1'b0);
    runCycle("st2_after_rst", C_IDLE, 16'd0);

    // Illegal opcode 1111: TRAP is terminal, ack pulses do nothing
    applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0);
    runCycle("ill_fetch", C_FETCH_A, 16'd0);
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
    runCycle("ill_decode", C_IDLE, 16'd0);
    applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0);
    runCycle("trap_ack1", C_TRAP, 16'd0);
    applyStimulus(4'b1101, 1'b0, 1'b0, 1'b0);
    runCycle("trap_noack", C_TRAP, 16'd0);
    applyStimulus(4'b1101, 1'b0, 1'b1, 1'b0);
    runCycle("trap_ack2", C_TRAP, 16'd0);
    applyStimulus(4'b1101, 1'b0, 1'b0, 1'b1);
    runCycle("trap_reset", C_TRAP, 16'd0);
    applyStimulus(4'b1010, 1'b0, 1'b0, 1'b0);
    runCycle("trap_rst_state", C_IDLE, 16'd0);
    runCycle("post_trap_fetch", C_FETCH_W, 16'd0);

    // Illegal opcode 1010 also traps
    applyStimulus(4'b1010, 1'b0, 1'b1, 1'b0);
    runCycle("ill2_fetch", C_FETCH_A, 16'd0);
    applyStimulus(4'b1010, 1'b0, 1'b0, 1'b0);
    runCycle("ill2_decode", C_IDLE, 16'd0);
    runCycle("ill2_trap", C_TRAP, 16'd0);

    // Counter wrap on 4-bit instance: retired = n after edge 1+3n following release
    wrap_reset = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    checkOutput("wrap_pre_max", {28'd0, w_retired}, 32'd14);
    @(posedge clk);
    #1;
    checkOutput("wrap_max", {28'd0, w_retired}, 32'd15);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("wrap_zero", {28'd0, w_retired}, 32'd0);
    checkOutput("wrap_no_trap", {31'd0, w_trap}, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
